// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared definitions for the mod-12 counter and its checker
// Contents: default modulus/width, tracking state enum, modular step function.
package counter_pkg;

  localparam int MOD_DEFAULT    = 12;
  localparam int DATA_W_DEFAULT = 4;

  typedef enum logic {
    ST_UNKNOWN = 1'b0,
    ST_TRACK   = 1'b1
  } state_t;

  // One modular step. The wrap is explicit so the result never depends on
  // the storage width of the caller.
  function automatic int unsigned next_count(input int unsigned base,
                                             input logic        up,
                                             input int unsigned mod = MOD_DEFAULT);
    if (up) begin
      return (base == mod - 32'd1) ? 32'd0 : base + 32'd1;
    end else begin
      return (base == 32'd0) ? mod - 32'd1 : base - 32'd1;
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
// Ports: clk, rst (sync, active-high), clr (sync clear), inc (count enable),
//        count [W-1:0] (holds at all-ones, never wraps).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/counter_checker.sv
// rtl/counter_checker.sv - passive monitor predicting and checking the mod-12 up/down load counter
// Ports: clk, rst (sync, active-high);
//        mon_rstn/mon_load/mon_up_down/mon_data_in: counter controls as the counter samples them;
//        mon_data_out: counter output produced by the previous edge;
//        exp_valid/exp_value: model state; err_pulse/range_err: one-cycle flags;
//        err_sticky: latched error; check_count/err_count: saturating counters.
module counter_checker
  import counter_pkg::*;
#(
  parameter int MOD    = MOD_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = 16,
  parameter int RESYNC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mon_rstn,
  input  logic              mon_load,
  input  logic              mon_up_down,
  input  logic [DATA_W-1:0] mon_data_in,
  input  logic [DATA_W-1:0] mon_data_out,
  output logic              exp_valid,
  output logic [DATA_W-1:0] exp_value,
  output logic              err_pulse,
  output logic              range_err,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  check_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int unsigned MOD_U = MOD;

  state_t            state;
  logic              tracking;
  logic              mismatch;
  logic              obs_bad;
  logic              load_ok;
  logic [DATA_W-1:0] base;

  always_comb begin
    tracking = (state == ST_TRACK);
    // 4-state compare: an X/Z on the observed bus is a mismatch, not a pass.
    mismatch = tracking && (mon_data_out !== exp_value);
    obs_bad  = (32'(mon_data_out) >= MOD_U) || $isunknown(mon_data_out);
    load_ok  = mon_load && (32'(mon_data_in) < MOD_U);
    // With resync the model follows the counter after a mismatch, so a single
    // glitch produces one error instead of an error on every later cycle.
    base     = ((RESYNC != 0) && mismatch) ? mon_data_out : exp_value;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_UNKNOWN;
      exp_value  <= '0;
      err_pulse  <= 1'b0;
      range_err  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err_pulse  <= mismatch;
      range_err  <= tracking && (32'(mon_data_out) >= MOD_U);
      err_sticky <= err_sticky | mismatch;

      if (!mon_rstn) begin
        state <= ST_UNKNOWN;
      end else if (load_ok) begin
        exp_value <= mon_data_in;
        state     <= ST_TRACK;
      end else if (tracking) begin
        // An out-of-range or unknown observation cannot seed the model.
        if ((RESYNC != 0) && mismatch && obs_bad) begin
          state <= ST_UNKNOWN;
        end else begin
          exp_value <= DATA_W'(next_count(32'(base), mon_up_down, MOD_U));
        end
      end
    end
  end

  assign exp_valid = tracking;

  sat_counter #(.W(CNT_W)) u_check_count (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (tracking),
    .count (check_count)
  );

  sat_counter #(.W(CNT_W)) u_err_count (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (mismatch),
    .count (err_count)
  );

endmodule

// File: tb/tb_counter_checker.sv
// tb/tb_counter_checker.sv - directed self-checking bench for counter_checker
module tb_counter_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       mon_rstn;
  logic       mon_load;
  logic       mon_up_down;
  logic [3:0] mon_data_in;
  logic [3:0] mon_data_out;

  logic        a_valid, a_pulse, a_range, a_sticky;
  logic [3:0]  a_value;
  logic [15:0] a_cc, a_ec;

  logic        b_valid, b_pulse, b_range, b_sticky;
  logic [3:0]  b_value;
  logic [15:0] b_cc, b_ec;

  logic        s_valid, s_pulse, s_range, s_sticky;
  logic [3:0]  s_value;
  logic [1:0]  s_cc, s_ec;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  counter_checker #(.MOD(12), .DATA_W(4), .CNT_W(16), .RESYNC(1)) dut (
    .clk(clk), .rst(rst), .mon_rstn(mon_rstn), .mon_load(mon_load),
    .mon_up_down(mon_up_down), .mon_data_in(mon_data_in), .mon_data_out(mon_data_out),
    .exp_valid(a_valid), .exp_value(a_value), .err_pulse(a_pulse), .range_err(a_range),
    .err_sticky(a_sticky), .check_count(a_cc), .err_count(a_ec)
  );

  counter_checker #(.MOD(12), .DATA_W(4), .CNT_W(16), .RESYNC(0)) dut_r0 (
    .clk(clk), .rst(rst), .mon_rstn(mon_rstn), .mon_load(mon_load),
    .mon_up_down(mon_up_down), .mon_data_in(mon_data_in), .mon_data_out(mon_data_out),
    .exp_valid(b_valid), .exp_value(b_value), .err_pulse(b_pulse), .range_err(b_range),
    .err_sticky(b_sticky), .check_count(b_cc), .err_count(b_ec)
  );

  counter_checker #(.MOD(12), .DATA_W(4), .CNT_W(2), .RESYNC(1)) dut_sat (
    .clk(clk), .rst(rst), .mon_rstn(mon_rstn), .mon_load(mon_load),
    .mon_up_down(mon_up_down), .mon_data_in(mon_data_in), .mon_data_out(mon_data_out),
    .exp_valid(s_valid), .exp_value(s_value), .err_pulse(s_pulse), .range_err(s_range),
    .err_sticky(s_sticky), .check_count(s_cc), .err_count(s_ec)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one set of observed signals, let one edge happen, settle after it.
  task automatic step(input logic rstn, input logic load, input logic up,
                      input logic [3:0] din, input logic [3:0] dout);
    mon_rstn     = rstn;
    mon_load     = load;
    mon_up_down  = up;
    mon_data_in  = din;
    mon_data_out = dout;
    @(posedge clk);
    #1;
  endtask

  // Up-wrap table: observed counter values and the model's next expectation.
  logic [3:0] up_obs [5] = '{4'd9, 4'd10, 4'd11, 4'd0, 4'd1};
  logic [3:0] up_exp [5] = '{4'd10, 4'd11, 4'd0, 4'd1, 4'd2};

  initial begin
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
    check("rst_exp_valid", 32'(a_valid), 0);
    check("rst_exp_value", 32'(a_value), 0);
    check("rst_err_pulse", 32'(a_pulse), 0);
    check("rst_range_err", 32'(a_range), 0);
    check("rst_sticky", 32'(a_sticky), 0);
    check("rst_check_count", 32'(a_cc), 0);
    check("rst_err_count", 32'(a_ec), 0);

    // Counter reset, then load 5
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    check("monrst_exp_valid", 32'(a_valid), 0);
    step(1'b1, 1'b1, 1'b1, 4'd5, 4'd0);
    check("load5_exp_valid", 32'(a_valid), 1);
    check("load5_exp_value", 32'(a_value), 5);
    check("load5_no_compare", 32'(a_cc), 0);

    // Load 9 (compares the 5), then count up through the wrap
    step(1'b1, 1'b1, 1'b1, 4'd9, 4'd5);
    check("load9_exp_value", 32'(a_value), 9);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, 4'd0, up_obs[i]);
      check($sformatf("up_exp_%0d", i), 32'(a_value), 32'(up_exp[i]));
      check($sformatf("up_pulse_%0d", i), 32'(a_pulse), 0);
    end
    check("up_check_count", 32'(a_cc), 6);

    // Load 1, count down through the wrap, then an illegal load of 13
    step(1'b1, 1'b1, 1'b0, 4'd1, 4'd2);
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd1);
    check("down_exp_0", 32'(a_value), 0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    check("down_exp_11", 32'(a_value), 11);
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd11);
    check("down_exp_10", 32'(a_value), 10);
    step(1'b1, 1'b1, 1'b0, 4'd13, 4'd10);
    check("illegal_load_exp_9", 32'(a_value), 9);
    check("down_err_count", 32'(a_ec), 0);
    check("down_check_count", 32'(a_cc), 11);

    // Injected fault: 7 observed where 4 is expected
    step(1'b1, 1'b1, 1'b1, 4'd3, 4'd9);
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd3);
    check("pre_fault_exp_4", 32'(a_value), 4);
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd7);
    check("fault_err_pulse", 32'(a_pulse), 1);
    check("fault_err_count", 32'(a_ec), 1);
    check("fault_sticky", 32'(a_sticky), 1);
    check("fault_resync_exp_8", 32'(a_value), 8);
    check("fault_keep_exp_5", 32'(b_value), 5);
    check("fault_keep_err_pulse", 32'(b_pulse), 1);
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd8);
    check("fault_pulse_one_cycle", 32'(a_pulse), 0);
    check("fault_sticky_holds", 32'(a_sticky), 1);
    check("post_fault_exp_9", 32'(a_value), 9);

    // Out-of-range observation drops the model to UNKNOWN
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd14);
    check("range_err_pulse", 32'(a_pulse), 1);
    check("range_err_flag", 32'(a_range), 1);
    check("range_exp_valid", 32'(a_valid), 0);
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
    check("unknown_err_pulse", 32'(a_pulse), 0);
    check("unknown_range_err", 32'(a_range), 0);
    check("unknown_exp_valid", 32'(a_valid), 0);
    check("unknown_check_count", 32'(a_cc), 16);

    // Reload, then three more mismatches to saturate the 2-bit counter
    step(1'b1, 1'b1, 1'b1, 4'd6, 4'd0);
    check("reload_exp_6", 32'(a_value), 6);
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
    check("resync_exp_1", 32'(a_value), 1);
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd5);
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd9);
    check("five_err_count", 32'(a_ec), 5);
    check("sat_err_count", 32'(s_ec), 3);
    check("sat_check_count", 32'(s_cc), 3);
    check("five_exp_10", 32'(a_value), 10);

    // Unknown value on the observed bus
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'bxxxx);
    check("x_err_pulse", 32'(a_pulse), 1);
    check("x_err_count", 32'(a_ec), 6);
    check("x_sat_err_count", 32'(s_ec), 3);

    // Mid-run checker reset
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
    check("midrst_exp_valid", 32'(a_valid), 0);
    check("midrst_exp_value", 32'(a_value), 0);
    check("midrst_err_pulse", 32'(a_pulse), 0);
    check("midrst_sticky", 32'(a_sticky), 0);
    check("midrst_err_count", 32'(a_ec), 0);
    check("midrst_check_count", 32'(a_cc), 0);
    check("midrst_sat_err_count", 32'(s_ec), 0);
    check("midrst_sat_sticky", 32'(s_sticky), 0);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd3);
    check("after_rst_no_track", 32'(a_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
